// File: rtl/rr_arb16_pkg.sv
// Shared types and sizes for the 16-channel round-robin arbiter.
package rr_arb16_pkg;

  localparam int unsigned NCH  = 16;  // number of requesters
  localparam int unsigned IDXW = 4;   // width of a channel index
  localparam int unsigned HCW  = 8;   // width of the grant hold counter

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/rr_arb16_pick.sv
// Circular priority search: first requesting channel at or above ptr, wrapping 15 -> 0.
module rr_pick
  import rr_arb16_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW-1:0] cand;

  // Walk the channels starting at ptr; 4-bit addition wraps the search naturally.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = ptr + IDXW'(i);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter for 16 requesters with a bounded grant hold time.
module rr_arb16
  import rr_arb16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_en,
  output logic            busy
);

  localparam logic [HCW-1:0] HoldLast = HCW'(MAX_HOLD - 1);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            en_q, en_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_q, hold_d;

  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state: grant from IDLE, count and release from GRANT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StGrant;
          idx_d   = pick_idx;
          en_d    = 1'b1;
          hold_d  = '0;
        end
      end
      StGrant: begin
        // Other req bits are deliberately not looked at while a grant is held.
        if (!req[idx_q] || (hold_q == HoldLast)) begin
          state_d = StIdle;
          en_d    = 1'b0;
          ptr_d   = idx_q + IDXW'(1);
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      en_q    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // busy shares the grant-valid flop so the two can never disagree.
  assign gnt_idx = idx_q;
  assign gnt_en  = en_q;
  assign busy    = en_q;

endmodule

// File: tb/tb_rr_arb16.sv
// Self-checking bench for rr_arb16: directed scenarios plus a randomized run against a model.
module tb_rr_arb16;

  localparam int MH = 8;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  gnt_idx;
  logic        gnt_en;
  logic        busy;

  logic [15:0] req1;
  logic [3:0]  gnt_idx1;
  logic        gnt_en1;
  logic        busy1;

  int n_pass;
  int n_total;

  rr_arb16 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .busy    (busy)
  );

  rr_arb16 #(.MAX_HOLD(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .req     (req1),
    .gnt_idx (gnt_idx1),
    .gnt_en  (gnt_en1),
    .busy    (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of dut: tracks whether a grant is held, to whom, how many
  // cycles it has lasted (1-based) and where the next search starts.
  bit     m_busy;
  int     m_idx;
  int     m_ptr;
  int     m_held;
  bit     m_found;
  int     m_c;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_idx  = 0;
      m_ptr  = 0;
      m_held = 0;
    end else if (m_busy) begin
      if (!req[m_idx] || m_held == MH) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 16;
      end else begin
        m_held = m_held + 1;
      end
    end else if (req != 16'h0) begin
      m_found = 0;
      for (int d = 0; d < 16; d++) begin
        m_c = (m_ptr + d) % 16;
        if (!m_found && req[m_c]) begin
          m_found = 1;
          m_idx   = m_c;
        end
      end
      m_busy = 1;
      m_held = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 16'h0;
    step();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 16'hffff;
    req1 = 16'hffff;
    step();
    step();
    n_total++;
    if ({gnt_en, busy, gnt_idx} !== 6'b0) begin
      $display("FAIL reset_state got en=%0b busy=%0b idx=%0d want 0/0/0", gnt_en, busy, gnt_idx);
    end else n_pass++;
    n_total++;
    if ({gnt_en1, busy1, gnt_idx1} !== 6'b0) begin
      $display("FAIL reset_state_mh1 got en=%0b busy=%0b idx=%0d want 0/0/0",
               gnt_en1, busy1, gnt_idx1);
    end else n_pass++;
    req1 = 16'h0;
  endtask

  task automatic test_hold_release();
    int len;
    do_reset();
    req = 16'h0001;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd0) begin
      $display("FAIL first_grant got en=%0b idx=%0d want 1/0", gnt_en, gnt_idx);
    end else n_pass++;
    len = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt_en !== 1'b1) break;
      len++;
    end
    n_total++;
    if (len !== MH) begin
      $display("FAIL hold_length got %0d want %0d", len, MH);
    end else n_pass++;
    n_total++;
    if (gnt_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL idle_after_release got en=%0b busy=%0b want 0/0", gnt_en, busy);
    end else n_pass++;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd0) begin
      $display("FAIL regrant got en=%0b idx=%0d want 1/0", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    step();
  endtask

  task automatic test_ptr_advance();
    do_reset();
    req = 16'h0008;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd3) begin
      $display("FAIL grant3 got en=%0b idx=%0d want 1/3", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    n_total++;
    if (gnt_en !== 1'b0 || gnt_idx !== 4'd3) begin
      $display("FAIL idx_hold_idle got en=%0b idx=%0d want 0/3", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0018;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd4) begin
      $display("FAIL ptr_after3 got en=%0b idx=%0d want 1/4", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h4000;
    step();
    req = 16'h0;
    step();
    req = 16'h0003;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd0) begin
      $display("FAIL wrap_0003 got en=%0b idx=%0d want 1/0", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    req = 16'h4000;
    step();
    req = 16'h0;
    step();
    req = 16'h8001;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd15) begin
      $display("FAIL wrap_8001 got en=%0b idx=%0d want 1/15", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    step();
  endtask

  task automatic test_drop_switch();
    do_reset();
    req = 16'h0020;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd5) begin
      $display("FAIL grant5 got en=%0b idx=%0d want 1/5", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0200;
    step();
    n_total++;
    if (gnt_en !== 1'b0) begin
      $display("FAIL drop_release got en=%0b want 0", gnt_en);
    end else n_pass++;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd9) begin
      $display("FAIL switch9 got en=%0b idx=%0d want 1/9", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 16'h0080;
    step();
    step();
    rst = 1'b1;
    step();
    n_total++;
    if ({gnt_en, busy, gnt_idx} !== 6'b0) begin
      $display("FAIL mid_reset got en=%0b busy=%0b idx=%0d want 0/0/0", gnt_en, busy, gnt_idx);
    end else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd7) begin
      $display("FAIL regrant7 got en=%0b idx=%0d want 1/7", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    step();
    // Move ptr to 4, reset mid-grant, then check the search restarts at 0.
    do_reset();
    req = 16'h0008;
    step();
    req = 16'h0;
    step();
    req = 16'h0080;
    step();
    rst = 1'b1;
    req = 16'h0088;
    step();
    rst = 1'b0;
    step();
    n_total++;
    if (gnt_en !== 1'b1 || gnt_idx !== 4'd3) begin
      $display("FAIL ptr_reset got en=%0b idx=%0d want 1/3", gnt_en, gnt_idx);
    end else n_pass++;
    req = 16'h0;
    step();
    step();
  endtask

  task automatic test_max_hold_one();
    logic       exp_en  [5];
    logic [3:0] exp_idx [5];
    exp_en  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_idx = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd1};
    do_reset();
    req1 = 16'h0006;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if (gnt_en1 !== exp_en[i] || gnt_idx1 !== exp_idx[i]) begin
        $display("FAIL mh1_cycle%0d got en=%0b idx=%0d want %0b/%0d",
                 i, gnt_en1, gnt_idx1, exp_en[i], exp_idx[i]);
      end else n_pass++;
    end
    req1 = 16'h0;
    step();
    step();
  endtask

  task automatic test_random();
    logic [15:0] req_prev;
    logic [15:0] onehot;
    logic        prev_en;
    logic [3:0]  prev_idx;
    int          waits [16];
    int          mx;
    do_reset();
    prev_en  = 1'b0;
    prev_idx = 4'd0;
    for (int k = 0; k < 16; k++) waits[k] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_prev = req;
      step();
      n_total++;
      if ({gnt_en, busy, gnt_idx} !== {m_busy, m_busy, 4'(m_idx)}) begin
        $display("FAIL rand_model cyc=%0d got en=%0b busy=%0b idx=%0d want en=busy=%0b idx=%0d",
                 cyc, gnt_en, busy, gnt_idx, m_busy, m_idx);
      end else n_pass++;
      onehot = gnt_en ? (16'h0001 << gnt_idx) : 16'h0;
      if (gnt_en && !prev_en) begin
        n_total++;
        if ((onehot & ~req_prev) !== 16'h0) begin
          $display("FAIL rand_subset cyc=%0d got onehot=%h want subset of %h",
                   cyc, onehot, req_prev);
        end else n_pass++;
      end
      if (prev_en && gnt_en) begin
        n_total++;
        if (gnt_idx !== prev_idx) begin
          $display("FAIL rand_b2b cyc=%0d got idx=%0d want %0d (no switch without idle)",
                   cyc, gnt_idx, prev_idx);
        end else n_pass++;
      end
      mx = 0;
      for (int k = 0; k < 16; k++) begin
        if (req_prev[k] && !(gnt_en && gnt_idx == 4'(k))) waits[k]++;
        else waits[k] = 0;
        if (waits[k] > mx) mx = waits[k];
      end
      n_total++;
      if (mx > 16 * (MH + 1)) begin
        $display("FAIL rand_starve cyc=%0d got wait=%0d want <= %0d", cyc, mx, 16 * (MH + 1));
      end else n_pass++;
      prev_en  = gnt_en;
      prev_idx = gnt_idx;
      req = req ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 63) == 0) req = 16'h0;
    end
    req = 16'h0;
    step();
    step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    req     = 16'h0;
    req1    = 16'h0;
    test_reset();
    test_hold_release();
    test_ptr_advance();
    test_wrap();
    test_drop_switch();
    test_reset_mid_grant();
    test_max_hold_one();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
